// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the up/down modulo counter family.
//
// Contents:
//   COUNT_UP / COUNT_DOWN  - encodings of the up_down direction input
//   counter_op_e           - per-edge operation chosen by the priority decoder
//   clog2()                - ceiling log2, used to check MODULUS against WIDTH
//
// Configuration macro used by the counter files: UPDOWN_COUNTER_SATURATE_EN.
package counter_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;

  // Operation applied at the next clock edge, decoded clear > load > step > hold.
  typedef enum logic [1:0] {
    OpHold  = 2'd0,
    OpStep  = 2'd1,
    OpLoad  = 2'd2,
    OpClear = 2'd3
  } counter_op_e;

  // Smallest n with 2**n >= value (clog2(1) = 0). Bounded loop so it stays a
  // legal constant function for elaboration-time checks.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/updown_mod_next.sv
// updown_mod_next: combinational next-count and limit-detect logic for
// updown_mod_counter. Holds no state.
//
// Ports:
//   count        in   WIDTH  current registered count
//   up_down      in   1      1 = up, 0 = down
//   count_enable in   1      step requested this cycle (only gates carry/borrow)
//   step_count   out  WIDTH  value count takes if a step is applied
//   limit_hit    out  1      the step would wrap (or saturate) at a range limit
//   carry        out  1      count_enable & up & (count == MODULUS-1)
//   borrow       out  1      count_enable & down & (count == 0)
//
// Macro UPDOWN_COUNTER_SATURATE_EN: when defined, a step at a limit holds the
// limit value instead of wrapping to the opposite end.
module updown_mod_next #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             count_enable,
  output logic [WIDTH-1:0] step_count,
  output logic             limit_hit,
  output logic             carry,
  output logic             borrow
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] WRAP_UP   = MAX_COUNT;
  localparam logic [WIDTH-1:0] WRAP_DOWN = '0;
`else
  localparam logic [WIDTH-1:0] WRAP_UP   = '0;
  localparam logic [WIDTH-1:0] WRAP_DOWN = MAX_COUNT;
`endif

  logic at_max;
  logic at_zero;
  logic count_up;

  assign at_max   = (count == MAX_COUNT);
  assign at_zero  = (count == '0);
  assign count_up = (up_down == COUNT_UP);

  // Carry/borrow stay combinational so a cascaded stage steps on the same edge.
  assign carry  = count_enable &  count_up & at_max;
  assign borrow = count_enable & ~count_up & at_zero;

  // Limits are tested before the increment/decrement, so no intermediate value
  // ever leaves 0..MODULUS-1 and no wider adder is needed.
  always_comb begin
    step_count = count;
    limit_hit  = 1'b0;
    if (count_up) begin
      if (at_max) begin
        step_count = WRAP_UP;
        limit_hit  = 1'b1;
      end else begin
        step_count = count + ONE;
      end
    end else begin
      if (at_zero) begin
        step_count = WRAP_DOWN;
        limit_hit  = 1'b1;
      end else begin
        step_count = count - ONE;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down, modulo-MODULUS, loadable counter
// with combinational carry/borrow for cascading and a sticky overflow flag.
//
// Parameters:
//   WIDTH        counter width (>= 1)
//   MODULUS      count range 0..MODULUS-1, legal 2..2**WIDTH
//   RESET_VALUE  value after reset or clear, < MODULUS
//
// Ports:
//   clock          in   1      rising-edge clock
//   reset          in   1      asynchronous active-high reset
//   count_enable   in   1      step the count this cycle
//   up_down        in   1      1 = up, 0 = down
//   clear          in   1      synchronous clear to RESET_VALUE (highest priority)
//   load           in   1      synchronous parallel load
//   load_value     in   WIDTH  value to load; >= MODULUS loads MODULUS-1 and flags
//   count          out  WIDTH  registered count
//   output_carry   out  1      combinational carry to the next (up) stage
//   output_borrow  out  1      combinational borrow to the next (down) stage
//   overflow       out  1      registered sticky flag, set on any limit hit
//   load_error     out  1      registered pulse after an out-of-range load
//
// Macro UPDOWN_COUNTER_SATURATE_EN: when defined, counting saturates at the
// range limits instead of wrapping; overflow and carry/borrow are unaffected.
module updown_mod_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 16,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             output_carry,
  output logic             output_borrow,
  output logic             overflow,
  output logic             load_error
);
  import counter_pkg::*;

  // Parameter legality, rejected at elaboration.
  if (WIDTH < 1 || MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("updown_mod_counter: RESET_VALUE must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             load_error_q, load_error_d;

  logic [WIDTH-1:0] step_count;
  logic             limit_hit;
  logic             load_in_range;
  counter_op_e      op;

  updown_mod_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count        (count_q),
    .up_down      (up_down),
    .count_enable (count_enable),
    .step_count   (step_count),
    .limit_hit    (limit_hit),
    .carry        (output_carry),
    .borrow       (output_borrow)
  );

  // Compared against MODULUS-1 in WIDTH bits so MODULUS == 2**WIDTH needs no
  // extra bit.
  assign load_in_range = (load_value <= MAX_COUNT);

  always_comb begin
    op = OpHold;
    if (clear) begin
      op = OpClear;
    end else if (load) begin
      op = OpLoad;
    end else if (count_enable) begin
      op = OpStep;
    end
  end

  always_comb begin
    count_d      = count_q;
    overflow_d   = overflow_q;
    load_error_d = 1'b0;
    unique case (op)
      OpClear: begin
        count_d    = RESET_COUNT;
        overflow_d = 1'b0;
      end
      OpLoad: begin
        if (load_in_range) begin
          count_d = load_value;
        end else begin
          count_d      = MAX_COUNT;
          load_error_d = 1'b1;
        end
      end
      OpStep: begin
        count_d = step_count;
        if (limit_hit) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q      <= RESET_COUNT;
      overflow_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      load_error_q <= load_error_d;
    end
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed, table-driven bench for updown_mod_counter.
// Main instance WIDTH=4, MODULUS=10, RESET_VALUE=0; a two-stage decade cascade;
// and a MODULUS=16, RESET_VALUE=5 instance. Expected values follow the build's
// UPDOWN_COUNTER_SATURATE_EN setting.
module tb_updown_mod_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Main instance
  logic       count_enable, up_down, clear, load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       output_carry, output_borrow, overflow, load_error;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut (
    .clock         (clock),
    .reset         (reset),
    .count_enable  (count_enable),
    .up_down       (up_down),
    .clear         (clear),
    .load          (load),
    .load_value    (load_value),
    .count         (count),
    .output_carry  (output_carry),
    .output_borrow (output_borrow),
    .overflow      (overflow),
    .load_error    (load_error)
  );

  // Two-stage decade cascade
  logic       cas_en, cas_ud;
  logic [3:0] lo_count, hi_count;
  logic       lo_carry, lo_borrow, lo_ovf, lo_lerr;
  logic       hi_carry, hi_borrow, hi_ovf, hi_lerr;
  logic       hi_en;

  assign hi_en = (cas_ud == 1'b1) ? lo_carry : lo_borrow;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
    .clock (clock), .reset (reset), .count_enable (cas_en), .up_down (cas_ud),
    .clear (1'b0), .load (1'b0), .load_value (4'd0), .count (lo_count),
    .output_carry (lo_carry), .output_borrow (lo_borrow), .overflow (lo_ovf),
    .load_error (lo_lerr)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
    .clock (clock), .reset (reset), .count_enable (hi_en), .up_down (cas_ud),
    .clear (1'b0), .load (1'b0), .load_value (4'd0), .count (hi_count),
    .output_carry (hi_carry), .output_borrow (hi_borrow), .overflow (hi_ovf),
    .load_error (hi_lerr)
  );

  // Full-range instance with non-zero reset value
  logic       m_en, m_clear;
  logic [3:0] m_count;
  logic       m_carry, m_borrow, m_ovf, m_lerr;

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(5)) u_m16 (
    .clock (clock), .reset (reset), .count_enable (m_en), .up_down (1'b1),
    .clear (m_clear), .load (1'b0), .load_value (4'd0), .count (m_count),
    .output_carry (m_carry), .output_borrow (m_borrow), .overflow (m_ovf),
    .load_error (m_lerr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       clr, ld, en, ud;
    logic [3:0] lv;
    logic [3:0] exp_count;
    logic       exp_carry, exp_borrow, exp_ovf, exp_lerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit clr, input bit ld, input bit en, input bit ud, input int lv,
                     input bit cy, input bit bw, input int cnt, input bit ov, input bit le);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.ud = ud; v.lv = 4'(lv);
    v.exp_carry = cy; v.exp_borrow = bw;
    v.exp_count = 4'(cnt); v.exp_ovf = ov; v.exp_lerr = le;
    vecs.push_back(v);
  endtask

  // Drive at negedge, check carry/borrow before the edge, registers after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    clear = v.clr; load = v.ld; count_enable = v.en; up_down = v.ud; load_value = v.lv;
    #1;
    check("carry", idx, 32'(output_carry), 32'(v.exp_carry));
    check("borrow", idx, 32'(output_borrow), 32'(v.exp_borrow));
    @(posedge clock);
    #1;
    check("count", idx, 32'(count), 32'(v.exp_count));
    check("overflow", idx, 32'(overflow), 32'(v.exp_ovf));
    check("load_error", idx, 32'(load_error), 32'(v.exp_lerr));
  endtask

  task automatic drive(input bit clr, input bit ld, input bit en, input bit ud, input int lv);
    @(negedge clock);
    clear = clr; load = ld; count_enable = en; up_down = ud; load_value = 4'(lv);
  endtask

  initial begin
    reset = 1'b1;
    count_enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = 4'd0;
    cas_en = 1'b0; cas_ud = 1'b1; m_en = 1'b0; m_clear = 1'b0;

    // Reset state
    #3;
    check("rst_count", 0, 32'(count), 0);
    check("rst_overflow", 0, 32'(overflow), 0);
    check("rst_load_error", 0, 32'(load_error), 0);
    check("rst_m16_count", 0, 32'(m_count), 5);
    @(negedge clock);
    reset = 1'b0;

    //   clr ld en ud lv  cy bw count            ov le
    for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 0, 0, 0, i, 0, 0);
    add(0, 0, 1, 1, 0,  1,   0,   SAT ? 9 : 0, 1, 0);     // wrap 9 -> 0
    add(0, 0, 1, 1, 0,  SAT, 0,   SAT ? 9 : 1, 1, 0);
    add(0, 0, 1, 1, 0,  SAT, 0,   SAT ? 9 : 2, 1, 0);
    add(0, 1, 0, 1, 0,  0,   0,   0,           1, 0);     // load 0
    add(0, 0, 1, 0, 0,  0,   1,   SAT ? 0 : 9, 1, 0);     // borrow 0 -> 9
    add(0, 0, 1, 0, 0,  0,   SAT, SAT ? 0 : 8, 1, 0);
    add(0, 1, 1, 1, 13, 0,   0,   9,           1, 1);     // bad load, enable ignored
    add(0, 0, 0, 1, 0,  0,   0,   9,           1, 0);     // carry needs enable
    add(0, 1, 0, 1, 5,  0,   0,   5,           1, 0);
    add(1, 1, 1, 1, 3,  0,   0,   0,           0, 0);     // clear wins
    add(0, 1, 0, 1, 15, 0,   0,   9,           0, 1);
    add(0, 1, 0, 1, 15, 0,   0,   9,           0, 1);     // back-to-back bad loads
    add(0, 1, 0, 1, 4,  0,   0,   4,           0, 0);
    add(0, 0, 1, 1, 0,  0,   0,   5,           0, 0);
    add(0, 0, 1, 0, 0,  0,   0,   4,           0, 0);     // direction change
    add(0, 0, 1, 1, 0,  0,   0,   5,           0, 0);
    add(0, 0, 0, 0, 0,  0,   0,   5,           0, 0);     // hold
    add(0, 1, 0, 1, 9,  0,   0,   9,           0, 0);
    add(0, 0, 1, 1, 0,  1,   0,   SAT ? 9 : 0, 1, 0);
    add(1, 0, 0, 1, 0,  0,   0,   0,           0, 0);
    add(0, 1, 0, 1, 12, 0,   0,   9,           0, 1);
    add(1, 0, 0, 1, 0,  0,   0,   0,           0, 0);     // clear drops load_error
    add(0, 0, 1, 0, 0,  0,   1,   SAT ? 0 : 9, 1, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Saturate / wrap from 8 upward
    drive(1, 0, 0, 1, 0);
    drive(0, 1, 0, 1, 8);
    drive(0, 0, 1, 1, 0);
    #1 check("sat_carry", 0, 32'(output_carry), 0);
    @(posedge clock); #1;
    check("sat_count", 0, 32'(count), 9);
    check("sat_ovf", 0, 32'(overflow), 0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clock); #1;
      check("sat_carry", i, 32'(output_carry), (SAT || i == 1) ? 1 : 0);
      @(posedge clock); #1;
      check("sat_count", i, 32'(count), SAT ? 9 : i - 1);
      check("sat_ovf", i, 32'(overflow), 1);
    end

    // Async reset mid-count at 7 with overflow set
    drive(0, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
    @(posedge clock); #1;
    check("pre_rst_count", 0, 32'(count), 7);
    check("pre_rst_ovf", 0, 32'(overflow), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_count", 0, 32'(count), 0);
    check("async_ovf", 0, 32'(overflow), 0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("resume_count", 0, 32'(count), 1);
    @(negedge clock);
    count_enable = 1'b0;

    // Cascade: 100 up steps, then one down step from 00
`ifndef UPDOWN_COUNTER_SATURATE_EN
    for (int s = 1; s <= 100; s++) begin
      @(negedge clock);
      cas_en = 1'b1; cas_ud = 1'b1;
      if (s == 100) begin
        #1 check("cas_hi_carry", s, 32'(hi_carry), 1);
      end
      @(posedge clock); #1;
      if (s == 37) begin
        check("cas_37", s, 32'({hi_count, lo_count}), 32'(8'h37));
      end
    end
    check("cas_100", 100, 32'({hi_count, lo_count}), 0);
    check("cas_hi_ovf", 100, 32'(hi_ovf), 1);
    check("cas_lo_ovf", 100, 32'(lo_ovf), 1);
    @(negedge clock);
    cas_ud = 1'b0;
    #1 check("cas_hi_borrow", 0, 32'(hi_borrow), 1);
    @(posedge clock); #1;
    check("cas_down", 0, 32'({hi_count, lo_count}), 32'(8'h99));
    @(negedge clock);
    cas_en = 1'b0;
`endif
    check("cas_lerr", 0, 32'({hi_lerr, lo_lerr}), 0);

    // MODULUS = 16, RESET_VALUE = 5: up 11 steps through 15
    @(negedge clock);
    m_en = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clock);
    #1 check("m16_carry", 0, 32'(m_carry), 1);
    check("m16_count15", 0, 32'(m_count), 15);
    @(posedge clock); #1;
    check("m16_wrap", 0, 32'(m_count), SAT ? 15 : 0);
    check("m16_ovf", 0, 32'(m_ovf), 1);
    @(negedge clock);
    m_en = 1'b0; m_clear = 1'b1;
    @(posedge clock); #1;
    check("m16_clear", 0, 32'(m_count), 5);
    check("m16_clear_ovf", 0, 32'(m_ovf), 0);
    check("m16_flags", 0, 32'({m_borrow, m_lerr}), 0);
    @(negedge clock);
    m_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit ripple-enable counter: synchronous up/down, modulo-N, loadable binary counter.
- Provides combinational carry/borrow outputs so instances chain into wider counters.
- Provides a registered sticky overflow flag.
- Used as the general counter primitive in the lab datapaths: timers, address generators and BCD digit stages.

Parameters:
- WIDTH, 4, counter bit width (>=1).
- MODULUS, 16, count range 0..MODULUS-1. Legal range is 2..2**WIDTH; an illegal value is an elaboration error.
- RESET_VALUE, 0, value of count after reset or clear. Must be < MODULUS.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- count_enable  input  1  advance the count by one step this cycle
- up_down  input  1  1 = count up, 0 = count down
- clear  input  1  synchronous clear to RESET_VALUE
- load  input  1  synchronous parallel load
- load_value  input  WIDTH  value to load
- count  output  WIDTH  current count (registered)
- output_carry  output  1  combinational: count_enable & up_down & (count == MODULUS-1)
- output_borrow  output  1  combinational: count_enable & ~up_down & (count == 0)
- overflow  output  1  registered sticky flag, set on any wrap or limit hit
- load_error  output  1  registered one-cycle pulse: last load had load_value >= MODULUS

Behaviour:
- Reset (async, any time, including mid-count):
  - count = RESET_VALUE
  - overflow = 0
  - load_error = 0
- Per-edge priority, highest first: clear > load > count_enable > hold.
- clear:
  - count = RESET_VALUE, overflow = 0, load_error = 0.
  - load and count_enable are ignored that cycle.
- load:
  - If load_value < MODULUS: count = load_value, load_error = 0.
  - Else: count = MODULUS-1, load_error = 1 for exactly one cycle.
  - count_enable is ignored that cycle. overflow is unchanged.
- count_enable with up_down = 1:
  - If count == MODULUS-1: count = 0 and overflow <= 1.
  - Else: count + 1.
- count_enable with up_down = 0:
  - If count == 0: count = MODULUS-1 and overflow <= 1.
  - Else: count - 1.
- count_enable = 0: count holds.
- load_error returns to 0 on any cycle without an out-of-range load.
- Latency:
  - count updates one cycle after the enabling edge.
  - output_carry and output_borrow are zero-latency combinational. They are asserted in the same cycle as the edge that wraps.
- Cascading:
  - Drive the next stage's count_enable from this stage's output_carry (up) or output_borrow (down).
  - Share up_down across all stages.
- Arithmetic:
  - Modulo MODULUS in WIDTH bits.
  - No intermediate value ever exceeds MODULUS-1.
  - count is never >= MODULUS in any reachable state.
- Direction change is legal on any cycle with no dead cycle; the new direction applies to the next enabled edge.
- With MODULUS = 2**WIDTH and up-only counting, behaviour is identical to the legacy ripple-enable counter.

Optional Feature:
- Macro: UPDOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counting up at MODULUS-1 holds at MODULUS-1 instead of wrapping.
  - Counting down at 0 holds at 0.
  - overflow still sets on the attempted step.
  - output_carry and output_borrow equations are unchanged.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Shared package counter_pkg:
  - constants COUNT_UP = 1'b1 and COUNT_DOWN = 1'b0
  - a ceiling-log2 function used for WIDTH checks
- One natural sub-module, updown_mod_next:
  - purely combinational next-count and limit-hit logic (carry, borrow, wrap target, saturate selection)
  - leaves the top module with only registers, priority muxing and flags

Test Plan (WIDTH=4, MODULUS=10, RESET_VALUE=0 unless stated):
- Reset, then count_enable=1, up_down=1 for 12 cycles:
  - count goes 1..9, 0, 1, 2
  - output_carry is high only while count=9
  - overflow=1 from the cycle after the wrap
- load_value=0, then count down 2 steps:
  - count goes 9, 8
  - output_borrow is high only while count=0
  - overflow=1
- load with load_value=13:
  - count=9 and load_error=1 for one cycle, then 0
  - a same-cycle count_enable is ignored
- clear, load and count_enable all asserted on the same edge with count=5:
  - count=0, overflow=0
- Reset asserted asynchronously mid-count at count=7, between clock edges:
  - count=0 and overflow=0 immediately
  - counting resumes on the first edge after reset deasserts
- Two stages cascaded via output_carry, MODULUS=10 each, 100 up steps:
  - combined value returns to 00
  - high stage overflow=1
- With UPDOWN_COUNTER_SATURATE_EN, repeated up steps from 8:
  - count sticks at 9
  - overflow=1
